// File: rtl/demux_1to4_1bit_seq_pkg.sv
// Shared state encoding and slot constants for the 1-to-4 serial deserializer
// and its dual-rail slot counter.
package demux_seq_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [1:0] SLOT0     = 2'd0;
    localparam logic [1:0] SLOT1     = 2'd1;
    localparam logic [1:0] SLOT2     = 2'd2;
    localparam logic [1:0] SLOT3     = 2'd3;
    localparam logic [1:0] LAST_SLOT = SLOT3;

endpackage

// File: rtl/demux_1to4_1bit_seq_if.sv
// Serial-in / word-out bus of the deserializer. slave = the deserializer,
// master = whoever feeds bits and consumes words.
interface demux_1to4_1bit_seq_if;
    logic       In;
    logic       InValid;
    logic       InReady;
    logic       Flush;
    logic [1:0] Select;
    logic [1:0] _Select;
    logic       Out0;
    logic       Out1;
    logic       Out2;
    logic       Out3;
    logic       WordValid;
    logic       WordReady;

    modport slave (
        input  In, InValid, Flush, WordReady,
        output InReady, Select, _Select, Out0, Out1, Out2, Out3, WordValid
    );

    modport master (
        output In, InValid, Flush, WordReady,
        input  InReady, Select, _Select, Out0, Out1, Out2, Out3, WordValid
    );
endinterface

// File: rtl/demux_1to4_1bit_seq_dualrail_sel_counter.sv
// 2-bit wrapping slot counter with registered true and complement rails, so the
// pair never disagrees, not even transiently. Shared with the serializer side.
module dualrail_sel_counter
    import demux_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [1:0] sel_o,
    output logic [1:0] sel_n_o
);

    logic [1:0] sel_q, sel_d;
    logic [1:0] sel_n_q;

    always_comb begin
        sel_d = sel_q;
        if (clr_i)
            sel_d = SLOT0;
        else if (inc_i)
            sel_d = sel_q + 2'd1;
    end

    // Both rails come from the same next-state value: no decode after the flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q   <= SLOT0;
            sel_n_q <= ~SLOT0;
        end else begin
            sel_q   <= sel_d;
            sel_n_q <= ~sel_d;
        end
    end

    assign sel_o   = sel_q;
    assign sel_n_o = sel_n_q;

endmodule

// File: rtl/demux_1to4_1bit_seq.sv
// Sequential 1-bit to 4-bit deserializer: bits are steered slot by slot into
// Out0..Out3 and each completed word is offered on WordValid/WordReady.
module demux_1to4_1bit_seq
    import demux_seq_pkg::*;
#(
    parameter bit AUTO_ACK = 1'b0
)(
    input  logic                         Clock,
    input  logic                         Reset,
    demux_1to4_1bit_seq_if.slave         bus
);

    state_e     state_q, state_d;
    logic       wv_q, wv_d;
    logic [3:0] out_q, out_d;
    logic [1:0] sel;
    logic [1:0] sel_n;
    logic       in_ready;
    logic       accept;
    logic       last;

    // Flush wins over a same-cycle bit; that bit is dropped.
    assign accept = bus.InValid & in_ready & ~bus.Flush;
    assign last   = accept & (sel == LAST_SLOT);

    dualrail_sel_counter u_sel (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .clr_i   (bus.Flush),
        .inc_i   (accept),
        .sel_o   (sel),
        .sel_n_o (sel_n)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FILL;
            wv_q    <= 1'b0;
            out_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            wv_q    <= wv_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wv_d    = 1'b0;
        out_d   = out_q;
        if (accept)
            out_d[sel] = bus.In;
        if (bus.Flush) begin
            state_d = FILL;
            wv_d    = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    wv_d = last;
                    if (last && !AUTO_ACK)
                        state_d = HOLD;
                end
                HOLD: begin
                    // InValid is ignored here, giving a one-cycle bubble on release.
                    wv_d = ~bus.WordReady;
                    if (bus.WordReady)
                        state_d = FILL;
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == FILL);
    end

    assign bus.InReady   = in_ready;
    assign bus.WordValid = wv_q;
    assign bus.Select    = sel;
    assign bus._Select   = sel_n;
    assign bus.Out0      = out_q[0];
    assign bus.Out1      = out_q[1];
    assign bus.Out2      = out_q[2];
    assign bus.Out3      = out_q[3];

endmodule

// File: tb/tb_demux_1to4_1bit_seq.sv
// Bench for the deserializer: one handshake instance and one auto-ack instance
// driven in parallel, checked by directed scenarios and a random run vs a word model.
module tb_demux_1to4_1bit_seq;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    bit   seen_rst = 0;

    demux_1to4_1bit_seq_if b0 ();
    demux_1to4_1bit_seq_if b1 ();

    demux_1to4_1bit_seq #(.AUTO_ACK(1'b0)) dut0 (.Clock(Clock), .Reset(Reset), .bus(b0));
    demux_1to4_1bit_seq #(.AUTO_ACK(1'b1)) dut1 (.Clock(Clock), .Reset(Reset), .bus(b1));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Word-level reference: bits collected so far, current word, pending flag.
    typedef struct {
        int         n;
        logic [3:0] w;
        bit         wv;
        bit         hold;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mstep(mdl_t m, bit aa, bit r, logic i, bit v, bit f, bit rd);
        mdl_t x;
        x = m;
        if (r) begin
            x.n = 0; x.w = 4'b0000; x.wv = 0; x.hold = 0;
        end else if (f) begin
            x.n = 0; x.wv = 0; x.hold = 0;
        end else if (x.hold) begin
            if (rd) begin x.hold = 0; x.wv = 0; end
        end else begin
            x.wv = 0;
            if (v) begin
                x.w[x.n] = i;
                x.n = (x.n + 1) % 4;
                if (x.n == 0) begin x.wv = 1; x.hold = !aa; end
            end
        end
        return x;
    endfunction

    // Both DUTs see the same stimulus; each model tracks its own instance.
    task automatic tick(input bit r, input logic i, input bit v, input bit f, input bit rd);
        Reset = r;
        b0.In = i; b0.InValid = v; b0.Flush = f; b0.WordReady = rd;
        b1.In = i; b1.InValid = v; b1.Flush = f; b1.WordReady = rd;
        @(posedge Clock);
        m0 = mstep(m0, 1'b0, r, i, v, f, rd);
        m1 = mstep(m1, 1'b1, r, i, v, f, rd);
        if (r) seen_rst = 1;
        #1;
    endtask

    always @(negedge Clock) begin
        if (seen_rst) begin
            checks++;
            if (b0._Select !== ~b0.Select || b1._Select !== ~b1.Select) begin
                errors++;
                $display("FAIL dualrail: sel0=%b nsel0=%b sel1=%b nsel1=%b", b0.Select, b0._Select, b1.Select, b1._Select);
            end
            checks++;
            if ($isunknown({b0.Select, b0._Select, b0.WordValid, b1.Select, b1._Select, b1.WordValid})) begin
                errors++;
                $display("FAIL no_x: sel0=%b nsel0=%b wv0=%b sel1=%b nsel1=%b wv1=%b",
                         b0.Select, b0._Select, b0.WordValid, b1.Select, b1._Select, b1.WordValid);
            end
        end
    end

    task automatic test_reset();
        tick(1, 0, 0, 0, 0);
        checks++;
        if ({b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.Select, b0._Select, b0.WordValid, b0.InReady} !== 10'b0000_00_11_0_1) begin
            errors++;
            $display("FAIL reset0: got out=%b%b%b%b sel=%b nsel=%b wv=%b rdy=%b expected 0000 00 11 0 1",
                     b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.Select, b0._Select, b0.WordValid, b0.InReady);
        end
        checks++;
        if ({b1.Out3, b1.Out2, b1.Out1, b1.Out0, b1.Select, b1._Select, b1.WordValid, b1.InReady} !== 10'b0000_00_11_0_1) begin
            errors++;
            $display("FAIL reset1: got out=%b%b%b%b sel=%b nsel=%b wv=%b rdy=%b expected 0000 00 11 0 1",
                     b1.Out3, b1.Out2, b1.Out1, b1.Out0, b1.Select, b1._Select, b1.WordValid, b1.InReady);
        end
    endtask

    task automatic test_fill();
        logic [3:0] bits;
        logic [1:0] es;
        bits = 4'b1101;  // sent in order bit0..bit3 = 1,0,1,1
        for (int k = 0; k < 4; k++) begin
            es = 2'(k);
            checks++;
            if (b0.Select !== es || b0._Select !== ~es) begin
                errors++;
                $display("FAIL fill_sel[%0d]: got %b/%b expected %b/%b", k, b0.Select, b0._Select, es, ~es);
            end
            tick(0, bits[k], 1, 0, 0);
        end
        checks++;
        if ({b0.Out3, b0.Out2, b0.Out1, b0.Out0} !== 4'b1101 || b0.WordValid !== 1'b1 || b0.InReady !== 1'b0 || b0.Select !== 2'b00) begin
            errors++;
            $display("FAIL fill_word: got out=%b%b%b%b wv=%b rdy=%b sel=%b expected 1101 1 0 00",
                     b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.WordValid, b0.InReady, b0.Select);
        end
        checks++;
        if (b1.WordValid !== 1'b1 || b1.InReady !== 1'b1 || {b1.Out3, b1.Out2, b1.Out1, b1.Out0} !== 4'b1101) begin
            errors++;
            $display("FAIL fill_auto: got wv=%b rdy=%b out=%b%b%b%b expected 1 1 1101",
                     b1.WordValid, b1.InReady, b1.Out3, b1.Out2, b1.Out1, b1.Out0);
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) begin
            tick(0, k[0], 1, 0, 0);
            checks++;
            if ({b0.Out3, b0.Out2, b0.Out1, b0.Out0} !== 4'b1101 || b0.WordValid !== 1'b1 || b0.Select !== 2'b00 || b0.InReady !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got out=%b%b%b%b wv=%b sel=%b rdy=%b expected 1101 1 00 0",
                         k, b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.WordValid, b0.Select, b0.InReady);
            end
        end
        tick(0, 0, 1, 0, 1);
        checks++;
        if (b0.WordValid !== 1'b0 || b0.InReady !== 1'b1 || b0.Select !== 2'b00 || {b0.Out3, b0.Out2, b0.Out1, b0.Out0} !== 4'b1101) begin
            errors++;
            $display("FAIL hold_release: got wv=%b rdy=%b sel=%b out=%b%b%b%b expected 0 1 00 1101",
                     b0.WordValid, b0.InReady, b0.Select, b0.Out3, b0.Out2, b0.Out1, b0.Out0);
        end
    endtask

    task automatic test_flush();
        logic [3:0] bits;
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 0);
        checks++;
        if (b0.Select !== 2'b10) begin
            errors++;
            $display("FAIL flush_pre: got sel=%b expected 10", b0.Select);
        end
        tick(0, 0, 1, 1, 0);
        checks++;
        if (b0.Select !== 2'b00 || b0.WordValid !== 1'b0 || {b0.Out3, b0.Out2, b0.Out1, b0.Out0} !== 4'b1111) begin
            errors++;
            $display("FAIL flush: got sel=%b wv=%b out=%b%b%b%b expected 00 0 1111",
                     b0.Select, b0.WordValid, b0.Out3, b0.Out2, b0.Out1, b0.Out0);
        end
        bits = 4'b1000;  // sent in order 0,0,0,1
        for (int k = 0; k < 4; k++) tick(0, bits[k], 1, 0, 0);
        checks++;
        if ({b0.Out3, b0.Out2, b0.Out1, b0.Out0} !== 4'b1000 || b0.WordValid !== 1'b1) begin
            errors++;
            $display("FAIL flush_next: got out=%b%b%b%b wv=%b expected 1000 1",
                     b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.WordValid);
        end
        tick(0, 0, 1, 1, 0);  // flush while holding drops the word
        checks++;
        if (b0.WordValid !== 1'b0 || b0.InReady !== 1'b1 || {b0.Out3, b0.Out2, b0.Out1, b0.Out0} !== 4'b1000) begin
            errors++;
            $display("FAIL flush_hold: got wv=%b rdy=%b out=%b%b%b%b expected 0 1 1000",
                     b0.WordValid, b0.InReady, b0.Out3, b0.Out2, b0.Out1, b0.Out0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bit         ewv;
        tick(1, 0, 0, 0, 0);
        bits = 8'b0110_0011;  // sent in order 1,1,0,0,0,1,1,0
        for (int k = 0; k < 8; k++) begin
            tick(0, bits[k], 1, 0, 0);
            ewv = (k == 3) || (k == 7);
            checks++;
            if (b1.WordValid !== ewv || b1.InReady !== 1'b1) begin
                errors++;
                $display("FAIL auto_pulse[%0d]: got wv=%b rdy=%b expected %b 1", k, b1.WordValid, b1.InReady, ewv);
            end
            if (k == 3) begin
                checks++;
                if ({b1.Out3, b1.Out2, b1.Out1, b1.Out0} !== 4'b0011) begin
                    errors++;
                    $display("FAIL auto_word1: got %b%b%b%b expected 0011", b1.Out3, b1.Out2, b1.Out1, b1.Out0);
                end
            end
            if (k == 7) begin
                checks++;
                if ({b1.Out3, b1.Out2, b1.Out1, b1.Out0} !== 4'b0110) begin
                    errors++;
                    $display("FAIL auto_word2: got %b%b%b%b expected 0110", b1.Out3, b1.Out2, b1.Out1, b1.Out0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) tick(0, 1, 1, 0, 0);
        tick(1, 1, 1, 1, 1);
        checks++;
        if ({b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.Select, b0._Select, b0.WordValid, b0.InReady} !== 10'b0000_00_11_0_1 ||
            {b1.Out3, b1.Out2, b1.Out1, b1.Out0, b1.Select, b1._Select, b1.WordValid, b1.InReady} !== 10'b0000_00_11_0_1) begin
            errors++;
            $display("FAIL reset_mid: got0 %b%b%b%b %b %b %b %b got1 %b%b%b%b %b %b %b %b expected 0000 00 11 0 1",
                     b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.Select, b0._Select, b0.WordValid, b0.InReady,
                     b1.Out3, b1.Out2, b1.Out1, b1.Out0, b1.Select, b1._Select, b1.WordValid, b1.InReady);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 49) == 0), logic'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0));
            checks++;
            if ({b0.Out3, b0.Out2, b0.Out1, b0.Out0} !== m0.w || b0.Select !== 2'(m0.n) ||
                b0.WordValid !== m0.wv || b0.InReady !== !m0.hold) begin
                errors++;
                $display("FAIL rand0[%0d]: got out=%b%b%b%b sel=%b wv=%b rdy=%b expected %b %b %b %b",
                         k, b0.Out3, b0.Out2, b0.Out1, b0.Out0, b0.Select, b0.WordValid, b0.InReady,
                         m0.w, 2'(m0.n), m0.wv, !m0.hold);
            end
            checks++;
            if ({b1.Out3, b1.Out2, b1.Out1, b1.Out0} !== m1.w || b1.Select !== 2'(m1.n) ||
                b1.WordValid !== m1.wv || b1.InReady !== !m1.hold) begin
                errors++;
                $display("FAIL rand1[%0d]: got out=%b%b%b%b sel=%b wv=%b rdy=%b expected %b %b %b %b",
                         k, b1.Out3, b1.Out2, b1.Out1, b1.Out0, b1.Select, b1.WordValid, b1.InReady,
                         m1.w, 2'(m1.n), m1.wv, !m1.hold);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        b0.In = 0; b0.InValid = 0; b0.Flush = 0; b0.WordReady = 0;
        b1.In = 0; b1.InValid = 0; b1.Flush = 0; b1.WordReady = 0;
        m0 = '{n: 0, w: 4'b0000, wv: 0, hold: 0};
        m1 = m0;
        test_reset();
        test_fill();
        test_hold();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_1to4_1bit_seq.md
Name: demux_1to4_1bit_seq

Overview:
- Sequential 1-bit-to-4-bit deserializer; the receive-side counterpart of the 4:1 1-bit dual-rail-select mux.
- Steers a serial bit stream into four output registers, slot by slot, using an internal 2-bit slot counter.
- Drives that counter out as a dual-rail select pair (Select/_Select), so a mux-based serializer at the far end can run in lockstep.
- Presents each completed 4-bit word on a valid/ready handshake.

Parameters:
- AUTO_ACK, 0: 0 = word is held in HOLD until WordReady; 1 = WordValid is a single-cycle pulse, WordReady is ignored, and there is no HOLD state.

Ports:
- Clock  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- In  input  1  serial data bit.
- InValid  input  1  In is valid this cycle.
- InReady  output  1  block can accept a bit this cycle.
- Flush  input  1  synchronous abort of the partial word.
- Select  output  2  current slot index (binary).
- _Select  output  2  bitwise complement of Select, always.
- Out0, Out1, Out2, Out3  output  1 each  deserialized word; Out0 holds the first bit received.
- WordValid  output  1  a complete word is present on Out0..Out3.
- WordReady  input  1  downstream consumes the word (used only when AUTO_ACK=0).

Behaviour:
- Reset values (Reset=1 at an edge): Out0..3=0, Select=2'b00, _Select=2'b11, WordValid=0, InReady=1, state=FILL.
- Reset has priority over every other input.
- Dual-rail invariant: _Select == ~Select in every cycle, including the reset cycle. Both are registered from the same counter; no combinational glitch path is permitted.
- States: FILL, HOLD.
- FILL: InReady=1.
  - Accept = InValid & InReady.
  - On accept: Out[Select] <= In, and Select increments mod 4.
  - Accept with Select==3: Select wraps to 0, WordValid <= 1 on the next edge, state goes to HOLD (AUTO_ACK=0) or stays in FILL (AUTO_ACK=1).
- HOLD (AUTO_ACK=0 only):
  - InReady=0, WordValid=1, Out0..3 frozen.
  - WordReady=1 -> WordValid <= 0, state goes to FILL.
  - InValid is ignored in HOLD, including the cycle WordReady is seen. This gives a 1-cycle bubble; no bit is accepted in that cycle.
- AUTO_ACK=1:
  - WordValid is high for exactly one cycle after the 4th accept.
  - Out0..3 stay stable only until the next accept. Back-to-back words are allowed: 4 bits in 4 consecutive cycles produce one WordValid pulse per 4 cycles.
- Latency: bit 4 accepted at edge N -> Out3 and WordValid visible after edge N (registered, one edge).
- Out registers change only on accept; no other path writes them except Reset.
- Flush=1 (synchronous, below Reset in priority):
  - Select <= 0, WordValid <= 0, state <= FILL; Out0..3 unchanged.
  - A same-cycle InValid is not accepted.
  - Flush in HOLD discards the pending word without a handshake.
- Illegal/unknown In while accepting is stored as-is; no X-filtering.
- The slot counter only counts; no other arithmetic. Width is fixed at 2 bits and wraps 3 -> 0.

Decomposition:
- Shared package demux_seq_pkg:
  - state encoding FILL=1'b0, HOLD=1'b1
  - slot constants SLOT0..SLOT3 = 2'd0..2'd3
  - LAST_SLOT = 2'd3
- One natural sub-module, dualrail_sel_counter: a 2-bit synchronous counter with inc, clear and reset inputs, outputting registered Select and _Select. It is reusable on the serializer side.

Test Plan:
- Reset, then bits 1,0,1,1 with InValid=1 on consecutive cycles (AUTO_ACK=0) -> Out0..3=1,0,1,1; WordValid=1 after the 4th edge; InReady=0. Select/_Select step 00/11, 01/10, 10/01, 11/00, then 00/11.
- Hold WordValid with WordReady=0 for 5 cycles while InValid=1 and In toggles -> Out0..3 stay 1,0,1,1 and no accept occurs. Assert WordReady -> WordValid=0 and InReady=1 next cycle.
- Send 2 bits (1,1), then Flush=1 with InValid=1 -> Select=00, WordValid stays 0, the Flush-cycle bit is not stored. The next 4 bits 0,0,0,1 give Out0..3=0,0,0,1.
- AUTO_ACK=1, 8 consecutive bits 1,1,0,0,0,1,1,0 -> WordValid pulses once after bit 4 (Out=1,1,0,0) and once after bit 8 (Out=0,1,1,0); InReady stays 1 throughout.
- Reset asserted mid-word (after 3 bits) together with Flush and InValid -> all outputs return to reset values next edge, including _Select=11.
- Checker on every cycle: _Select == ~Select, and no X on Select, _Select or WordValid after the first reset.
